// File: rtl/approx_metrics_pkg.sv
// Shared types and constants for the approximate adder error monitor.
// Holds the FSM state encoding, result widths and the MAE grading bound.
package approx_metrics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // err_sum needs 3W bits: 2^(2W) samples of at most 2^W-1 each
    function automatic int sum_width(input int w);
        return 3 * w;
    endfunction

    // err_cnt must hold the full count 2^(2W), hence one extra bit
    function automatic int cnt_width(input int w);
        return 2 * w + 1;
    endfunction

    // floor(err_sum / N) <= MAE_LIMIT  <=>  err_sum < (MAE_LIMIT+1) * N
    function automatic logic [63:0] mae_bound(input int mae_limit,
                                              input int w);
        logic [63:0] v;
        v = 64'(mae_limit + 1);
        return v << (2 * w);
    endfunction

endpackage

// File: rtl/err_accum.sv
// Error statistics accumulator: worst case, total and count of
// nonzero absolute differences between exact and approximate sums.
module err_accum
    import approx_metrics_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clr,
    input  logic                        i_valid,
    input  logic [WIDTH-1:0]            i_exact,
    input  logic [WIDTH-1:0]            i_approx,
    output logic [WIDTH-1:0]            o_wce,
    output logic [sum_width(WIDTH)-1:0] o_err_sum,
    output logic [cnt_width(WIDTH)-1:0] o_err_cnt
);

    localparam int SW = sum_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] w_diff;
    logic             w_nz;
    logic [WIDTH-1:0] r_wce;
    logic [SW-1:0]    r_err_sum;
    logic [CW-1:0]    r_err_cnt;

    // unsigned absolute difference, never wider than the sum itself
    always_comb begin
        w_diff = '0;
        if (i_exact >= i_approx) begin
            w_diff = i_exact - i_approx;
        end else begin
            w_diff = i_approx - i_exact;
        end
    end

    assign w_nz = (w_diff != '0);

    // accumulate only tagged samples; clear wins over accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wce     <= '0;
            r_err_sum <= '0;
            r_err_cnt <= '0;
        end else if (i_clr) begin
            r_wce     <= '0;
            r_err_sum <= '0;
            r_err_cnt <= '0;
        end else if (i_valid) begin
            if (w_diff > r_wce) begin
                r_wce <= w_diff;
            end
            r_err_sum <= r_err_sum + SW'(w_diff);
            r_err_cnt <= r_err_cnt + {{(CW-1){1'b0}}, w_nz};
        end
    end

    assign o_wce     = r_wce;
    assign o_err_sum = r_err_sum;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Exhaustive error characterisation of a W-bit approximate adder:
// sweeps all operand pairs, aligns the exact sum to DUT latency, grades.
module approx_adder_error_monitor
    import approx_metrics_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DUT_LAT   = 0,
    parameter int WCE_LIMIT = 50,
    parameter int MAE_LIMIT = 50
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [WIDTH-1:0]            op_a,
    output logic [WIDTH-1:0]            op_b,
    input  logic [WIDTH-1:0]            dut_sum,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            wce,
    output logic [sum_width(WIDTH)-1:0] err_sum,
    output logic [cnt_width(WIDTH)-1:0] err_cnt,
    output logic                        pass
);

    localparam int          VW      = 2 * WIDTH;
    localparam int          DCW     = $clog2(DUT_LAT + 2);
    localparam logic [63:0] MAE_BND = mae_bound(MAE_LIMIT, WIDTH);

    state_t           r_state;
    logic [VW-1:0]    r_vec;
    logic [DCW-1:0]   r_drain;
    logic             r_busy;
    logic             r_done;

    logic             w_start_ok;
    logic             w_last;
    logic             w_vld0;
    logic [WIDTH-1:0] w_exact;
    logic             w_acc_vld;
    logic [WIDTH-1:0] w_acc_exact;

    assign w_start_ok = start &&
                        (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last     = (r_vec == '1);
    assign w_vld0     = (r_state == ST_SWEEP);

    assign op_a    = r_vec[VW-1:WIDTH];
    assign op_b    = r_vec[WIDTH-1:0];
    assign w_exact = op_a + op_b;

    // sweep control: counter, drain timer and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_vec   <= '0;
                        r_drain <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    r_vec <= r_vec + VW'(1);
                    if (w_last) begin
                        r_drain <= '0;
                        if (DUT_LAT == 0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_drain <= r_drain + DCW'(1);
                    if (r_drain == DCW'(DUT_LAT - 1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // exact sum and valid tag delayed to line up with dut_sum
    if (DUT_LAT == 0) begin : g_comb
        assign w_acc_vld   = w_vld0;
        assign w_acc_exact = w_exact;
    end else begin : g_pipe
        logic [DUT_LAT-1:0] r_pvld;
        logic [WIDTH-1:0]   r_pex [DUT_LAT];

        // shift register; a new sweep flushes stale tags
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pvld <= '0;
                for (int k = 0; k < DUT_LAT; k++) begin
                    r_pex[k] <= '0;
                end
            end else if (w_start_ok) begin
                r_pvld <= '0;
                for (int k = 0; k < DUT_LAT; k++) begin
                    r_pex[k] <= '0;
                end
            end else begin
                r_pvld[0] <= w_vld0;
                r_pex[0]  <= w_exact;
                for (int k = 1; k < DUT_LAT; k++) begin
                    r_pvld[k] <= r_pvld[k-1];
                    r_pex[k]  <= r_pex[k-1];
                end
            end
        end

        assign w_acc_vld   = r_pvld[DUT_LAT-1];
        assign w_acc_exact = r_pex[DUT_LAT-1];
    end

    err_accum #(
        .WIDTH (WIDTH)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_start_ok),
        .i_valid   (w_acc_vld),
        .i_exact   (w_acc_exact),
        .i_approx  (dut_sum),
        .o_wce     (wce),
        .o_err_sum (err_sum),
        .o_err_cnt (err_cnt)
    );

    assign busy = r_busy;
    assign done = r_done;

    // grading; wce > 0 rejects a circuit that is actually exact
    assign pass = r_done &&
                  (64'(wce) <= 64'(WCE_LIMIT)) &&
                  (64'(err_sum) < MAE_BND) &&
                  (wce != '0);

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench: five W=8 monitors swept in parallel against different DUTs,
// plus a W=2 monitor for reset-abort, ignored start and restart.
module tb_approx_adder_error_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    always #5 clk = ~clk;

    logic [7:0]  opa [5];
    logic [7:0]  opb [5];
    logic [7:0]  sm  [5];
    logic [7:0]  wce [5];
    logic [23:0] es  [5];
    logic [16:0] ec  [5];
    logic        bsy [5];
    logic        dn  [5];
    logic        ps  [5];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int LAT = (g == 3) ? 2 : ((g == 4) ? 1 : 0);
        logic [7:0] w_ex;
        assign w_ex = opa[g] + opb[g];
        if (g == 0) begin : g_exact
            assign sm[g] = w_ex;
        end else if (g == 1) begin : g_b0
            assign sm[g] = w_ex & 8'hFE;
        end else if (g == 2) begin : g_b50
            assign sm[g] = w_ex & 8'hC0;
        end else begin : g_reg
            logic [7:0] r1;
            logic [7:0] r2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r1 <= '0;
                    r2 <= '0;
                end else begin
                    r1 <= w_ex & 8'hFE;
                    r2 <= r1;
                end
            end
            assign sm[g] = r2;
        end
        approx_adder_error_monitor #(
            .WIDTH   (8),
            .DUT_LAT (LAT)
        ) u_mon (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .op_a    (opa[g]),
            .op_b    (opb[g]),
            .dut_sum (sm[g]),
            .busy    (bsy[g]),
            .done    (dn[g]),
            .wce     (wce[g]),
            .err_sum (es[g]),
            .err_cnt (ec[g]),
            .pass    (ps[g])
        );
    end

    logic       rst2_n;
    logic       start2;
    logic [1:0] opa2, opb2, sm2, wce2;
    logic [5:0] es2;
    logic [4:0] ec2;
    logic       bsy2, dn2, ps2;
    logic [1:0] w_ex2;

    assign w_ex2 = opa2 + opb2;
    assign sm2   = w_ex2 & 2'b10;

    approx_adder_error_monitor #(
        .WIDTH   (2),
        .DUT_LAT (0)
    ) u_mon2 (
        .clk     (clk),
        .rst_n   (rst2_n),
        .start   (start2),
        .op_a    (opa2),
        .op_b    (opb2),
        .dut_sum (sm2),
        .busy    (bsy2),
        .done    (dn2),
        .wce     (wce2),
        .err_sum (es2),
        .err_cnt (ec2),
        .pass    (ps2)
    );

    typedef struct {
        string       name;
        logic [7:0]  wce;
        logic [23:0] es;
        logic [16:0] ec;
        logic        ps;
        int          dcyc;
        bit          stats;
    } vec_t;

    vec_t tbl [5];
    int   total = 0;
    int   bad   = 0;
    int   dcy [5];
    int   cyc;
    int   ndone;
    int   c;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pulse2();
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"exact", 8'd0, 24'd0, 17'd0, 1'b0, 65537, 1'b1};
        tbl[1] = '{"bit0", 8'd1, 24'd32768, 17'd32768, 1'b1, 65537,
                   1'b1};
        tbl[2] = '{"bits50", 8'd63, 24'd2064384, 17'd64512, 1'b0,
                   65537, 1'b1};
        tbl[3] = '{"lat2", 8'd1, 24'd32768, 17'd32768, 1'b1, 65539,
                   1'b1};
        tbl[4] = '{"misalign", 8'd0, 24'd0, 17'd0, 1'b0, 65538, 1'b0};

        rst_n  = 1'b0;
        rst2_n = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rst_flags%0d", g),
                64'({bsy[g], dn[g], ps[g]}), 64'(0));
            chk($sformatf("rst_stats%0d", g),
                64'({wce[g], es[g], ec[g]}), 64'(0));
            chk($sformatf("rst_ops%0d", g),
                64'({opa[g], opb[g]}), 64'(0));
        end
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        chk("c1_busy", 64'({bsy[0], dn[0]}), 64'(2'b10));
        chk("c1_ops", 64'({opa[0], opb[0]}), 64'(0));
        for (int g = 0; g < 5; g++) dcy[g] = 0;
        ndone = 0;
        while (ndone < 5 && cyc < 70000) begin
            for (int g = 0; g < 5; g++) begin
                if (dn[g] && dcy[g] == 0) begin
                    dcy[g] = cyc;
                    ndone++;
                end
            end
            if (cyc == 300) begin
                chk("c300_ops", 64'({opa[0], opb[0]}), 64'(299));
            end
            if (ndone < 5) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end

        for (int i = 0; i < 5; i++) begin
            chk({tbl[i].name, "_done_cyc"}, 64'(dcy[i]),
                64'(tbl[i].dcyc));
            chk({tbl[i].name, "_busy"}, 64'(bsy[i]), 64'(0));
            if (tbl[i].stats) begin
                chk({tbl[i].name, "_wce"}, 64'(wce[i]),
                    64'(tbl[i].wce));
                chk({tbl[i].name, "_err_sum"}, 64'(es[i]),
                    64'(tbl[i].es));
                chk({tbl[i].name, "_err_cnt"}, 64'(ec[i]),
                    64'(tbl[i].ec));
                chk({tbl[i].name, "_pass"}, 64'(ps[i]),
                    64'(tbl[i].ps));
            end else begin
                total++;
                if (!(wce[i] > 8'd1)) begin
                    bad++;
                    $display("FAIL %s_wce: got %0d want >1",
                             tbl[i].name, wce[i]);
                end
            end
        end

        pulse2();
        c = 0;
        while ({opa2, opb2} != 4'd7 && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("w2_reach7", 64'({opa2, opb2}), 64'(7));
        chk("w2_pre_wce", 64'(wce2), 64'(1));
        rst2_n = 1'b0;
        #1;
        chk("w2_rst_flags", 64'({bsy2, dn2, ps2}), 64'(0));
        chk("w2_rst_stats", 64'({wce2, es2, ec2}), 64'(0));
        chk("w2_rst_ops", 64'({opa2, opb2}), 64'(0));
        @(negedge clk);
        rst2_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("w2_idle", 64'({bsy2, dn2}), 64'(0));

        for (int run = 0; run < 2; run++) begin
            pulse2();
            c = 1;
            if (run == 1) begin
                chk("w2_restart_done", 64'(dn2), 64'(0));
                chk("w2_restart_stats", 64'({wce2, es2, ec2}), 64'(0));
                chk("w2_restart_busy", 64'(bsy2), 64'(1));
            end else begin
                repeat (4) @(posedge clk);
                #1;
                @(negedge clk);
                start2 = 1'b1;
                @(posedge clk);
                #1;
                start2 = 1'b0;
                c = 6;
                chk("w2_ign_start", 64'({opa2, opb2}), 64'(5));
            end
            while (!dn2 && c < 100) begin
                @(posedge clk);
                #1;
                c++;
            end
            chk($sformatf("w2_done_cyc%0d", run), 64'(c), 64'(17));
            chk($sformatf("w2_wce%0d", run), 64'(wce2), 64'(1));
            chk($sformatf("w2_es%0d", run), 64'(es2), 64'(8));
            chk($sformatf("w2_ec%0d", run), 64'(ec2), 64'(8));
            chk($sformatf("w2_pass%0d", run), 64'(ps2), 64'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
